// File: rtl/soft_body_step_ctrl.sv
// rtl/soft_body_step_ctrl.sv - per-frame soft-body step sequencer
// Launches the spring engine, buffers per-node forces with gravity, then runs the integrator.
module soft_body_step_ctrl #(
  parameter int NUM_NODES      = 10,
  parameter int FORCE_SIZE     = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int IDXW          = $clog2(NUM_NODES)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  frame_tick_in,
  input  logic [FORCE_SIZE-1:0] gravity_in,
  output logic                  ideal_start_out,
  input  logic                  ideal_force_valid_in,
  input  logic [FORCE_SIZE-1:0] ideal_force_x_in,
  input  logic [FORCE_SIZE-1:0] ideal_force_y_in,
  input  logic                  ideal_done_in,
  input  logic [FORCE_SIZE-1:0] axle_force_x_in,
  input  logic [FORCE_SIZE-1:0] axle_force_y_in,
  output logic                  integ_start_out,
  input  logic                  integ_done_in,
  input  logic [IDXW-1:0]       force_rd_idx_in,
  output logic [FORCE_SIZE-1:0] force_rd_x_out,
  output logic [FORCE_SIZE-1:0] force_rd_y_out,
  output logic [FORCE_SIZE-1:0] axle_force_x_out,
  output logic [FORCE_SIZE-1:0] axle_force_y_out,
  output logic                  busy_out,
  output logic                  frame_done_out,
  output logic [2:0]            err_out,
  input  logic                  clear_err_in
);

  localparam int CNTW = $clog2(NUM_NODES + 1);
  localparam int TMW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FORCE_SIZE-1:0] F_MAX = {1'b0, {(FORCE_SIZE-1){1'b1}}};
  localparam logic [FORCE_SIZE-1:0] F_MIN = {1'b1, {(FORCE_SIZE-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_COLLECT,
    S_INTEGRATE,
    S_FINISH
  } state_e;

  state_e                state_q, state_d;
  logic [CNTW-1:0]       beat_cnt_q, beat_cnt_d;
  logic [TMW-1:0]        timer_q, timer_d;
  logic [FORCE_SIZE-1:0] fx_q [NUM_NODES];
  logic [FORCE_SIZE-1:0] fx_d [NUM_NODES];
  logic [FORCE_SIZE-1:0] fy_q [NUM_NODES];
  logic [FORCE_SIZE-1:0] fy_d [NUM_NODES];
  logic [FORCE_SIZE-1:0] axle_x_q, axle_x_d;
  logic [FORCE_SIZE-1:0] axle_y_q, axle_y_d;
  logic [2:0]            err_q, err_d;
  logic                  timeout_hit;

  // Sum at one extra bit; a sign disagreement between the top two bits means overflow.
  function automatic logic [FORCE_SIZE-1:0] sat_add(input logic [FORCE_SIZE-1:0] a,
                                                    input logic [FORCE_SIZE-1:0] b);
    logic [FORCE_SIZE:0] s;
    s = {a[FORCE_SIZE-1], a} + {b[FORCE_SIZE-1], b};
    if (s[FORCE_SIZE] != s[FORCE_SIZE-1]) begin
      return s[FORCE_SIZE] ? F_MIN : F_MAX;
    end
    return s[FORCE_SIZE-1:0];
  endfunction

  assign timeout_hit = (timer_q == TMW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d         = state_q;
    beat_cnt_d      = beat_cnt_q;
    timer_d         = timer_q;
    fx_d            = fx_q;
    fy_d            = fy_q;
    axle_x_d        = axle_x_q;
    axle_y_d        = axle_y_q;
    err_d           = clear_err_in ? 3'b000 : err_q;
    ideal_start_out = 1'b0;
    integ_start_out = 1'b0;
    frame_done_out  = 1'b0;

    if (frame_tick_in && (state_q != S_IDLE)) begin
      err_d[0] = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (frame_tick_in) begin
          state_d    = S_LAUNCH;
          beat_cnt_d = '0;
          timer_d    = '0;
          for (int i = 0; i < NUM_NODES; i++) begin
            fx_d[i] = '0;
            fy_d[i] = '0;
          end
        end
      end
      S_LAUNCH: begin
        ideal_start_out = 1'b1;
        timer_d         = '0;
        state_d         = S_COLLECT;
      end
      S_COLLECT: begin
        if (ideal_force_valid_in) begin
          if (beat_cnt_q < CNTW'(NUM_NODES)) begin
            for (int i = 0; i < NUM_NODES; i++) begin
              if (beat_cnt_q == CNTW'(i)) begin
                fx_d[i] = ideal_force_x_in;
                fy_d[i] = sat_add(ideal_force_y_in, gravity_in);
              end
            end
            beat_cnt_d = beat_cnt_q + CNTW'(1);
          end else begin
            err_d[1] = 1'b1;
          end
        end
        if (ideal_done_in) begin
          axle_x_d = axle_force_x_in;
          axle_y_d = sat_add(axle_force_y_in, gravity_in);
          timer_d  = '0;
          state_d  = S_INTEGRATE;
        end else if (timeout_hit) begin
          err_d[2] = 1'b1;
          state_d  = S_IDLE;
        end else begin
          timer_d = timer_q + TMW'(1);
        end
      end
      S_INTEGRATE: begin
        // Timer is zeroed on entry, so zero marks the first integrate cycle.
        integ_start_out = (timer_q == '0);
        if (integ_done_in) begin
          state_d = S_FINISH;
        end else if (timeout_hit) begin
          err_d[2] = 1'b1;
          state_d  = S_IDLE;
        end else begin
          timer_d = timer_q + TMW'(1);
        end
      end
      S_FINISH: begin
        frame_done_out = 1'b1;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= S_IDLE;
      beat_cnt_q <= '0;
      timer_q    <= '0;
      axle_x_q   <= '0;
      axle_y_q   <= '0;
      err_q      <= '0;
      for (int i = 0; i < NUM_NODES; i++) begin
        fx_q[i] <= '0;
        fy_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      timer_q    <= timer_d;
      axle_x_q   <= axle_x_d;
      axle_y_q   <= axle_y_d;
      err_q      <= err_d;
      for (int i = 0; i < NUM_NODES; i++) begin
        fx_q[i] <= fx_d[i];
        fy_q[i] <= fy_d[i];
      end
    end
  end

  // Out-of-range read indices match no entry and fall through to zero.
  always_comb begin
    force_rd_x_out = '0;
    force_rd_y_out = '0;
    for (int i = 0; i < NUM_NODES; i++) begin
      if (force_rd_idx_in == IDXW'(i)) begin
        force_rd_x_out = fx_q[i];
        force_rd_y_out = fy_q[i];
      end
    end
  end

  assign axle_force_x_out = axle_x_q;
  assign axle_force_y_out = axle_y_q;
  assign busy_out         = (state_q != S_IDLE);
  assign err_out          = err_q;

endmodule

// File: tb/tb_soft_body_step_ctrl.sv
// tb/tb_soft_body_step_ctrl.sv - directed self-checking bench for soft_body_step_ctrl
module tb_soft_body_step_ctrl;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b0;
  logic       frame_tick_in = 1'b0;
  logic [7:0] gravity_in = '0;
  logic       ideal_start_out;
  logic       ideal_force_valid_in = 1'b0;
  logic [7:0] ideal_force_x_in = '0;
  logic [7:0] ideal_force_y_in = '0;
  logic       ideal_done_in = 1'b0;
  logic [7:0] axle_force_x_in = '0;
  logic [7:0] axle_force_y_in = '0;
  logic       integ_start_out;
  logic       integ_done_in = 1'b0;
  logic [3:0] force_rd_idx_in = '0;
  logic [7:0] force_rd_x_out;
  logic [7:0] force_rd_y_out;
  logic [7:0] axle_force_x_out;
  logic [7:0] axle_force_y_out;
  logic       busy_out;
  logic       frame_done_out;
  logic [2:0] err_out;
  logic       clear_err_in = 1'b0;

  int total = 0;
  int bad = 0;
  int fd_cnt = 0;
  int is_cnt = 0;

  soft_body_step_ctrl #(.NUM_NODES(10), .FORCE_SIZE(8), .TIMEOUT_CYCLES(1024)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .frame_tick_in(frame_tick_in), .gravity_in(gravity_in),
    .ideal_start_out(ideal_start_out), .ideal_force_valid_in(ideal_force_valid_in),
    .ideal_force_x_in(ideal_force_x_in), .ideal_force_y_in(ideal_force_y_in),
    .ideal_done_in(ideal_done_in), .axle_force_x_in(axle_force_x_in),
    .axle_force_y_in(axle_force_y_in), .integ_start_out(integ_start_out),
    .integ_done_in(integ_done_in), .force_rd_idx_in(force_rd_idx_in),
    .force_rd_x_out(force_rd_x_out), .force_rd_y_out(force_rd_y_out),
    .axle_force_x_out(axle_force_x_out), .axle_force_y_out(axle_force_y_out),
    .busy_out(busy_out), .frame_done_out(frame_done_out), .err_out(err_out),
    .clear_err_in(clear_err_in)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (frame_done_out) fd_cnt++;
    if (ideal_start_out) is_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic start_frame();
    frame_tick_in = 1'b1;
    cyc();
    frame_tick_in = 1'b0;
    cyc();
  endtask

  task automatic beat(input logic [7:0] x, input logic [7:0] y);
    ideal_force_valid_in = 1'b1;
    ideal_force_x_in = x;
    ideal_force_y_in = y;
    cyc();
    ideal_force_valid_in = 1'b0;
  endtask

  task automatic ideal_finish(input logic [7:0] ax, input logic [7:0] ay);
    ideal_done_in = 1'b1;
    axle_force_x_in = ax;
    axle_force_y_in = ay;
    cyc();
    ideal_done_in = 1'b0;
  endtask

  task automatic integ_finish();
    integ_done_in = 1'b1;
    cyc();
    integ_done_in = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    repeat (3) cyc();
    total++;
    if ({busy_out, ideal_start_out, integ_start_out, frame_done_out} !== 4'b0000) begin
      bad++; $display("FAIL reset_ctrl: got %b want 0000",
                      {busy_out, ideal_start_out, integ_start_out, frame_done_out});
    end
    total++;
    if ({err_out, axle_force_x_out, axle_force_y_out, force_rd_x_out, force_rd_y_out} !== '0) begin
      bad++; $display("FAIL reset_data: err=%b ax=%0h ay=%0h rx=%0h ry=%0h want 0",
                      err_out, axle_force_x_out, axle_force_y_out, force_rd_x_out, force_rd_y_out);
    end
    rst_in = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    gravity_in = 8'(-2);
    frame_tick_in = 1'b1;
    cyc();
    frame_tick_in = 1'b0;
    total++;
    if (ideal_start_out !== 1'b1 || busy_out !== 1'b1) begin
      bad++; $display("FAIL basic_launch: start=%b busy=%b want 1 1", ideal_start_out, busy_out);
    end
    cyc();
    total++;
    if (ideal_start_out !== 1'b0) begin
      bad++; $display("FAIL basic_start_width: got %b want 0", ideal_start_out);
    end
    for (int k = 0; k < 10; k++) beat(8'(k), 8'(k));
    ideal_finish(8'd5, 8'd3);
    total++;
    if (integ_start_out !== 1'b1) begin
      bad++; $display("FAIL basic_integ_start: got %b want 1", integ_start_out);
    end
    cyc();
    total++;
    if (integ_start_out !== 1'b0 || busy_out !== 1'b1) begin
      bad++; $display("FAIL basic_integ_width: start=%b busy=%b want 0 1", integ_start_out, busy_out);
    end
    for (int k = 0; k < 10; k++) begin
      force_rd_idx_in = 4'(k);
      #1;
      total++;
      if (force_rd_x_out !== 8'(k) || force_rd_y_out !== 8'(k - 2)) begin
        bad++; $display("FAIL basic_node%0d: got x=%0d y=%0d want x=%0d y=%0d", k,
                        $signed(force_rd_x_out), $signed(force_rd_y_out), k, k - 2);
      end
    end
    integ_done_in = 1'b1;
    cyc();
    integ_done_in = 1'b0;
    total++;
    if (frame_done_out !== 1'b1) begin
      bad++; $display("FAIL basic_frame_done: got %b want 1", frame_done_out);
    end
    cyc();
    total++;
    if (frame_done_out !== 1'b0 || busy_out !== 1'b0) begin
      bad++; $display("FAIL basic_idle: done=%b busy=%b want 0 0", frame_done_out, busy_out);
    end
    total++;
    if (axle_force_x_out !== 8'd5 || axle_force_y_out !== 8'd1 || err_out !== 3'b000) begin
      bad++; $display("FAIL basic_axle: ax=%0d ay=%0d err=%b want 5 1 000",
                      $signed(axle_force_x_out), $signed(axle_force_y_out), err_out);
    end
  endtask

  task automatic test_saturation();
    logic [7:0] exp_y [4];
    exp_y[0] = 8'h80; exp_y[1] = 8'd127; exp_y[2] = 8'd25; exp_y[3] = 8'd0;
    gravity_in = 8'(-100);
    start_frame();
    beat(8'd0, 8'(-100));
    gravity_in = 8'd20;
    beat(8'd1, 8'd120);
    beat(8'd2, 8'd5);
    ideal_finish(8'(-7), 8'd120);
    for (int k = 0; k < 4; k++) begin
      force_rd_idx_in = 4'(k);
      #1;
      total++;
      if (force_rd_y_out !== exp_y[k]) begin
        bad++; $display("FAIL sat_node%0d_y: got %0d want %0d", k,
                        $signed(force_rd_y_out), $signed(exp_y[k]));
      end
    end
    total++;
    if (axle_force_x_out !== 8'(-7) || axle_force_y_out !== 8'd127) begin
      bad++; $display("FAIL sat_axle: ax=%0d ay=%0d want -7 127",
                      $signed(axle_force_x_out), $signed(axle_force_y_out));
    end
    integ_finish();
  endtask

  task automatic test_overflow();
    gravity_in = 8'd0;
    start_frame();
    for (int k = 0; k < 12; k++) beat(8'(k + 1), 8'(-(k + 1)));
    total++;
    if (err_out !== 3'b010) begin
      bad++; $display("FAIL ovf_err: got %b want 010", err_out);
    end
    ideal_finish(8'd0, 8'd0);
    integ_finish();
    for (int k = 0; k < 10; k++) begin
      force_rd_idx_in = 4'(k);
      #1;
      total++;
      if (force_rd_x_out !== 8'(k + 1) || force_rd_y_out !== 8'(-(k + 1))) begin
        bad++; $display("FAIL ovf_node%0d: got x=%0d y=%0d want x=%0d y=%0d", k,
                        $signed(force_rd_x_out), $signed(force_rd_y_out), k + 1, -(k + 1));
      end
    end
    clear_err_in = 1'b1;
    cyc();
    clear_err_in = 1'b0;
    total++;
    if (err_out !== 3'b000) begin
      bad++; $display("FAIL ovf_clear: got %b want 000", err_out);
    end
    start_frame();
    for (int k = 0; k < 4; k++) beat(8'(10 + k), 8'(20 + k));
    ideal_finish(8'd0, 8'd0);
    for (int k = 0; k < 16; k++) begin
      force_rd_idx_in = 4'(k);
      #1;
      total++;
      if (k < 4 && (force_rd_x_out !== 8'(10 + k) || force_rd_y_out !== 8'(20 + k))) begin
        bad++; $display("FAIL short_node%0d: got x=%0d y=%0d want x=%0d y=%0d", k,
                        $signed(force_rd_x_out), $signed(force_rd_y_out), 10 + k, 20 + k);
      end else if (k >= 4 && (force_rd_x_out !== 8'd0 || force_rd_y_out !== 8'd0)) begin
        bad++; $display("FAIL short_node%0d: got x=%0d y=%0d want x=0 y=0", k,
                        $signed(force_rd_x_out), $signed(force_rd_y_out));
      end
    end
    integ_finish();
    total++;
    if (err_out !== 3'b000) begin
      bad++; $display("FAIL short_err: got %b want 000", err_out);
    end
  endtask

  task automatic test_overrun();
    int fd0;
    int is0;
    fd0 = fd_cnt;
    gravity_in = 8'd0;
    start_frame();
    is0 = is_cnt;
    beat(8'd1, 8'd1);
    frame_tick_in = 1'b1;
    cyc();
    frame_tick_in = 1'b0;
    total++;
    if (err_out !== 3'b001 || busy_out !== 1'b1) begin
      bad++; $display("FAIL overrun_err: err=%b busy=%b want 001 1", err_out, busy_out);
    end
    frame_tick_in = 1'b1;
    clear_err_in = 1'b1;
    cyc();
    frame_tick_in = 1'b0;
    clear_err_in = 1'b0;
    total++;
    if (err_out !== 3'b001) begin
      bad++; $display("FAIL overrun_set_wins: got %b want 001", err_out);
    end
    ideal_finish(8'd9, 8'd9);
    integ_finish();
    total++;
    if (fd_cnt !== fd0 + 1 || is_cnt !== is0) begin
      bad++; $display("FAIL overrun_complete: frames=%0d starts=%0d want %0d %0d",
                      fd_cnt - fd0, is_cnt - is0, 1, 0);
    end
    clear_err_in = 1'b1;
    cyc();
    clear_err_in = 1'b0;
    total++;
    if (err_out !== 3'b000) begin
      bad++; $display("FAIL overrun_clear: got %b want 000", err_out);
    end
  endtask

  task automatic test_timeout();
    int fd0;
    fd0 = fd_cnt;
    start_frame();
    beat(8'd3, 8'd4);
    beat(8'd5, 8'd6);
    repeat (1021) cyc();
    total++;
    if (busy_out !== 1'b1 || err_out !== 3'b000) begin
      bad++; $display("FAIL timeout_early: busy=%b err=%b want 1 000", busy_out, err_out);
    end
    cyc();
    total++;
    if (busy_out !== 1'b0 || err_out !== 3'b100 || fd_cnt !== fd0) begin
      bad++; $display("FAIL timeout_abort: busy=%b err=%b frames=%0d want 0 100 0",
                      busy_out, err_out, fd_cnt - fd0);
    end
    force_rd_idx_in = 4'd1;
    #1;
    total++;
    if (force_rd_x_out !== 8'd5 || force_rd_y_out !== 8'd6) begin
      bad++; $display("FAIL timeout_partial: got x=%0d y=%0d want 5 6",
                      $signed(force_rd_x_out), $signed(force_rd_y_out));
    end
    clear_err_in = 1'b1;
    cyc();
    clear_err_in = 1'b0;
  endtask

  task automatic test_reset_mid();
    int fd0;
    int is0;
    start_frame();
    beat(8'd7, 8'd7);
    beat(8'd8, 8'd8);
    #3;
    rst_in = 1'b0;
    #1;
    force_rd_idx_in = 4'd0;
    #1;
    total++;
    if ({busy_out, ideal_start_out, integ_start_out, frame_done_out, err_out} !== 7'b0 ||
        {axle_force_x_out, axle_force_y_out, force_rd_x_out, force_rd_y_out} !== 32'h0) begin
      bad++; $display("FAIL midrst_outputs: busy=%b err=%b ax=%0h rx=%0h want all 0",
                      busy_out, err_out, axle_force_x_out, force_rd_x_out);
    end
    cyc();
    rst_in = 1'b1;
    fd0 = fd_cnt;
    is0 = is_cnt;
    repeat (3) cyc();
    total++;
    if (fd_cnt !== fd0 || is_cnt !== is0 || busy_out !== 1'b0) begin
      bad++; $display("FAIL midrst_quiet: frames=%0d starts=%0d busy=%b want 0 0 0",
                      fd_cnt - fd0, is_cnt - is0, busy_out);
    end
    gravity_in = 8'd1;
    start_frame();
    for (int k = 0; k < 10; k++) beat(8'(k), 8'(2 * k));
    ideal_finish(8'd11, 8'(-11));
    integ_finish();
    for (int k = 0; k < 10; k++) begin
      force_rd_idx_in = 4'(k);
      #1;
      total++;
      if (force_rd_x_out !== 8'(k) || force_rd_y_out !== 8'(2 * k + 1)) begin
        bad++; $display("FAIL clean_node%0d: got x=%0d y=%0d want x=%0d y=%0d", k,
                        $signed(force_rd_x_out), $signed(force_rd_y_out), k, 2 * k + 1);
      end
    end
    total++;
    if (fd_cnt !== fd0 + 1 || is_cnt !== is0 + 1 || err_out !== 3'b000) begin
      bad++; $display("FAIL clean_step: frames=%0d starts=%0d err=%b want 1 1 000",
                      fd_cnt - fd0, is_cnt - is0, err_out);
    end
  endtask

  task automatic test_ignored_done();
    ideal_done_in = 1'b1;
    integ_done_in = 1'b1;
    axle_force_x_in = 8'd50;
    axle_force_y_in = 8'd50;
    cyc();
    ideal_done_in = 1'b0;
    integ_done_in = 1'b0;
    cyc();
    total++;
    if (busy_out !== 1'b0 || axle_force_x_out !== 8'd11 || axle_force_y_out !== 8'(-10)) begin
      bad++; $display("FAIL idle_done_ignored: busy=%b ax=%0d ay=%0d want 0 11 -10",
                      busy_out, $signed(axle_force_x_out), $signed(axle_force_y_out));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_overflow();
    test_overrun();
    test_timeout();
    test_reset_mid();
    test_ignored_done();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
